// File: rtl/spi_byte_engine.sv
// ============================================================================
// Module   : spi_byte_engine
// Purpose  : Mode-0 SPI master byte shifter with RX holding register or FIFO,
//            and synchronised, edge-detected device interrupt flag.
// Options  : define SPI_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO (RX_DEPTH >= 2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_engine #(
   parameter int CLK_DIV  = 2,
   parameter int RX_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       overrun,
   input  logic       ovr_clear,
   input  logic       ss_req,
   output logic       busy,
   output logic       SS,
   output logic       SCLK,
   output logic       MOSI,
   input  logic       MISO,
   input  logic       INT,
   output logic       int_pending,
   input  logic       int_clear
);

   localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("spi_byte_engine: CLK_DIV must be >= 1");
   end
   if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_rx_depth
      $error("spi_byte_engine: RX_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q,  state_d;
   logic [DIV_W-1:0]   div_q,    div_d;
   logic [2:0]         bitcnt_q, bitcnt_d;
   logic [7:0]         shreg_q,  shreg_d;
   logic               mosi_q,   mosi_d;
   logic               sclk_q,   sclk_d;
   logic               ss_q,     ss_d;
   logic               overrun_q, overrun_d;
   logic               int_meta_q, int_meta_d;
   logic               int_sync_q, int_sync_d;
   logic               int_prev_q, int_prev_d;
   logic               int_pending_q, int_pending_d;

   logic               accept;
   logic               done;
   logic               ovr_set;
   logic               int_fall;

   assign tx_ready    = (state_q == ST_IDLE) & RESET;
   assign busy        = (state_q != ST_IDLE);
   assign accept      = tx_valid & tx_ready;
   assign done        = (state_q == ST_DONE);
   assign SS          = ss_q;
   assign SCLK        = sclk_q;
   assign MOSI        = mosi_q;
   assign overrun     = overrun_q;
   assign int_pending = int_pending_q;

   // ------------------------------------------------------------------------
   // Shift engine: the shift register holds the remaining TX bits on the left
   // and collects MISO on the right, so after 8 rising edges it holds the RX byte.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      mosi_d   = mosi_q;
      sclk_d   = sclk_q;
      ss_d     = ss_q;

      case (state_q)
         ST_IDLE: begin
            sclk_d = 1'b0;
            ss_d   = ~ss_req;
            if (accept) begin
               shreg_d  = tx_data;
               bitcnt_d = 3'd7;
               mosi_d   = tx_data[7];
               div_d    = '0;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               sclk_d  = 1'b1;
               shreg_d = {shreg_q[6:0], MISO};
               state_d = ST_HIGH;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_HIGH: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = 1'b0;
               if (bitcnt_q == 3'd0) begin
                  state_d = ST_DONE;
               end else begin
                  mosi_d   = shreg_q[7];
                  bitcnt_d = bitcnt_q - 3'd1;
                  state_d  = ST_SETUP;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         mosi_q   <= 1'b0;
         sclk_q   <= 1'b0;
         ss_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         mosi_q   <= mosi_d;
         sclk_q   <= sclk_d;
         ss_q     <= ss_d;
      end
   end

   // ------------------------------------------------------------------------
   // Receive path
   // ------------------------------------------------------------------------
`ifdef SPI_RX_FIFO_EN
   localparam int PTR_W = $clog2(RX_DEPTH);

   logic [7:0]     mem_q [RX_DEPTH];
   logic [7:0]     mem_d [RX_DEPTH];
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic           fifo_empty;
   logic           fifo_full;
   logic           pop;
   logic           push_ok;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop        = rx_ack & ~fifo_empty;
   assign push_ok    = done & (~fifo_full | pop);
   assign ovr_set    = done & fifo_full & ~pop;
   assign rx_valid   = ~fifo_empty;
   assign rx_data    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = shreg_q;
         wr_ptr_d                   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < RX_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end
`else
   logic [7:0] rx_data_q,  rx_data_d;
   logic       rx_valid_q, rx_valid_d;

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign ovr_set  = done & rx_valid_q & ~rx_ack;

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      if (done) begin
         rx_data_d  = shreg_q;
         rx_valid_d = 1'b1;
      end else if (rx_ack) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Sticky flags and interrupt conditioning
   // ------------------------------------------------------------------------
   assign int_fall = int_prev_q & ~int_sync_q;

   always_comb begin
      overrun_d     = ovr_set | (overrun_q & ~ovr_clear);
      int_meta_d    = INT;
      int_sync_d    = int_meta_q;
      int_prev_d    = int_sync_q;
      int_pending_d = int_fall | (int_pending_q & ~int_clear);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         overrun_q     <= 1'b0;
         int_meta_q    <= 1'b1;
         int_sync_q    <= 1'b1;
         int_prev_q    <= 1'b1;
         int_pending_q <= 1'b0;
      end else begin
         overrun_q     <= overrun_d;
         int_meta_q    <= int_meta_d;
         int_sync_q    <= int_sync_d;
         int_prev_q    <= int_prev_d;
         int_pending_q <= int_pending_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_engine.sv
// ============================================================================
// Module   : tb_spi_byte_engine
// Purpose  : Scoreboard bench for spi_byte_engine (loopback, MISO model,
//            overrun / FIFO, mid-transfer reset, interrupt flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_byte_engine;

   localparam int CLK_DIV = 2;
   localparam int LAT     = 16 * CLK_DIV + 1;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       overrun;
   logic       ovr_clear = 1'b0;
   logic       ss_req = 1'b0;
   logic       busy;
   logic       SS;
   logic       SCLK;
   logic       MOSI;
   logic       MISO;
   logic       INT = 1'b1;
   logic       int_pending;
   logic       int_clear = 1'b0;

   logic       loop_mode = 1'b1;
   logic [7:0] miso_byte = 8'h00;
   logic [2:0] miso_cnt  = 3'd0;
   logic       auto_ack  = 1'b1;
   logic       man_ack   = 1'b0;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];

   logic       sclk_s [0:255];
   logic       mosi_s [0:255];
   logic       ss_s   [0:255];
   logic       rxv_s  [0:255];

   always #5 CLK = ~CLK;

   // Slave model: presents miso_byte MSB first, advancing after each rising SCLK.
   always @(posedge SCLK or negedge RESET) begin
      if (!RESET) miso_cnt <= 3'd0;
      else        miso_cnt <= miso_cnt + 3'd1;
   end
   assign MISO   = loop_mode ? MOSI : miso_byte[3'd7 - miso_cnt];
   assign rx_ack = auto_ack ? rx_valid : man_ack;

   spi_byte_engine #(.CLK_DIV(CLK_DIV), .RX_DEPTH(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
      .overrun(overrun), .ovr_clear(ovr_clear),
      .ss_req(ss_req), .busy(busy),
      .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .INT(INT), .int_pending(int_pending), .int_clear(int_clear)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_byte(input logic [7:0] b, input bit push, input logic [7:0] exp);
      int n;
      n = 0;
      while (!tx_ready && n < 200) begin
         tick();
         n++;
      end
      if (!tx_ready) chk("tx_ready_timeout", {31'd0, tx_ready}, 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      if (push) exp_q.push_back(exp);
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic finish_byte(output int lat);
      lat       = 0;
      sclk_s[0] = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         tick();
         sclk_s[n] = SCLK;
         mosi_s[n] = MOSI;
         ss_s[n]   = SS;
         rxv_s[n]  = rx_valid;
         if (tx_ready) begin
            lat = n;
            break;
         end
      end
      if (lat == 0) chk("xfer_timeout", {31'd0, tx_ready}, 32'd1);
   endtask

   initial begin
      int         lat;
      int         rises;
      int         run;
      int         bad_w;
      int         ss_hi;
      logic [7:0] pat;

      // Scoreboard monitor: every consumed RX byte must match the queue head.
      fork
         forever begin
            @(negedge CLK);
            if (RESET && rx_valid && rx_ack) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL rx_unexpected: got 0x%0h with no byte expected", rx_data);
               end else begin
                  chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
               end
            end
         end
      join_none

      // ---------------- reset state ----------------
      repeat (3) tick();
      chk("rst_SS",       {31'd0, SS},          32'd1);
      chk("rst_SCLK",     {31'd0, SCLK},        32'd0);
      chk("rst_MOSI",     {31'd0, MOSI},        32'd0);
      chk("rst_busy",     {31'd0, busy},        32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid},    32'd0);
      chk("rst_rx_data",  {24'd0, rx_data},     32'd0);
      chk("rst_overrun",  {31'd0, overrun},     32'd0);
      chk("rst_int_pend", {31'd0, int_pending}, 32'd0);
      chk("rst_tx_ready", {31'd0, tx_ready},    32'd0);
      RESET = 1'b1;
      tick();
      chk("tx_ready_after_rst", {31'd0, tx_ready}, 32'd1);

      // ---------------- loopback 0xA5 ----------------
      ss_req = 1'b1;
      tick();
      chk("ss_assert", {31'd0, SS}, 32'd0);
      start_byte(8'hA5, 1'b1, 8'hA5);
      finish_byte(lat);
      chk("lat_a5", lat, LAT);
      chk("rx_valid_at_lat", {31'd0, rxv_s[lat]},     32'd1);
      chk("rx_valid_early",  {31'd0, rxv_s[lat - 1]}, 32'd0);
      rises = 0; run = 0; bad_w = 0; ss_hi = 0; pat = 8'h00;
      for (int n = 1; n <= lat; n++) begin
         if (sclk_s[n] && !sclk_s[n - 1]) begin
            pat = {pat[6:0], mosi_s[n]};
            rises++;
         end
         if (sclk_s[n]) run++;
         else if (run != 0) begin
            if (run != CLK_DIV) bad_w++;
            run = 0;
         end
         if (ss_s[n]) ss_hi++;
      end
      chk("sclk_rises",      rises, 8);
      chk("sclk_high_width", bad_w, 0);
      chk("mosi_pattern",    {24'd0, pat}, 32'h0000_00A5);
      chk("ss_low_in_xfer",  ss_hi, 0);
      chk("mosi_hold_last",  {31'd0, MOSI}, 32'd1);
      chk("sclk_idle_low",   {31'd0, SCLK}, 32'd0);

      // ---------------- MISO model 0x3C, send 0xFF ----------------
      loop_mode = 1'b0;
      miso_byte = 8'h3C;
      start_byte(8'hFF, 1'b1, 8'h3C);
      finish_byte(lat);
      chk("lat_ff", lat, LAT);
      tick();
      loop_mode = 1'b1;

`ifndef SPI_RX_FIFO_EN
      // ---------------- overrun on holding register ----------------
      auto_ack = 1'b0;
      start_byte(8'h11, 1'b0, 8'h00);
      finish_byte(lat);
      chk("ovr_first_clear", {31'd0, overrun}, 32'd0);
      start_byte(8'h22, 1'b1, 8'h22);
      finish_byte(lat);
      chk("ovr_rx_data",  {24'd0, rx_data},  32'h0000_0022);
      chk("ovr_set",      {31'd0, overrun},  32'd1);
      chk("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
      ovr_clear = 1'b1;
      tick();
      ovr_clear = 1'b0;
      chk("ovr_cleared", {31'd0, overrun}, 32'd0);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("ack_clears_valid", {31'd0, rx_valid}, 32'd0);
      auto_ack = 1'b1;
`else
      // ---------------- FIFO fill past depth ----------------
      auto_ack = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         start_byte(8'(i), (i <= 4), 8'(i));
         finish_byte(lat);
      end
      chk("fifo_ovr",      {31'd0, overrun},  32'd1);
      chk("fifo_head",     {24'd0, rx_data},  32'd1);
      man_ack = 1'b1;
      repeat (4) tick();
      man_ack = 1'b0;
      chk("fifo_drained",  {31'd0, rx_valid}, 32'd0);
      ovr_clear = 1'b1;
      tick();
      ovr_clear = 1'b0;
      chk("fifo_ovr_clear", {31'd0, overrun}, 32'd0);
      auto_ack = 1'b1;
`endif

      // ---------------- reset during bit 3 ----------------
      start_byte(8'hC3, 1'b0, 8'h00);
      repeat (9 * CLK_DIV + 1) tick();
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      RESET = 1'b0;
      tick();
      chk("abort_SS",       {31'd0, SS},       32'd1);
      chk("abort_SCLK",     {31'd0, SCLK},     32'd0);
      chk("abort_busy",     {31'd0, busy},     32'd0);
      chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
      RESET = 1'b1;
      tick();
      start_byte(8'h5A, 1'b1, 8'h5A);
      finish_byte(lat);
      chk("lat_after_abort", lat, LAT);
      tick();

      // ---------------- interrupt conditioning ----------------
      INT = 1'b0;
      tick();
      chk("int_e1", {31'd0, int_pending}, 32'd0);
      tick();
      chk("int_e2", {31'd0, int_pending}, 32'd0);
      tick();
      chk("int_e3", {31'd0, int_pending}, 32'd1);
      int_clear = 1'b1;
      tick();
      int_clear = 1'b0;
      chk("int_cleared", {31'd0, int_pending}, 32'd0);
      tick();
      INT = 1'b1;
      chk("int_once", {31'd0, int_pending}, 32'd0);
      repeat (4) tick();
      chk("int_idle", {31'd0, int_pending}, 32'd0);
      INT       = 1'b0;
      int_clear = 1'b1;
      repeat (3) tick();
      chk("int_set_wins", {31'd0, int_pending}, 32'd1);
      int_clear = 1'b0;
      INT       = 1'b1;

      repeat (5) tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
